sap1_controller: RTL

//  Control sequencer for the SAP-1 datapath. Advances a 6-state T-cycle
//  (T1..T6) and decodes the IR opcode into the control word on the shared
//  8-bit bus: PC inc/load/output, MAR, RAM, IR, A, B, ALU and OUT register.

---
 rtl/sap1_controller_if.sv | 48 ++++
 rtl/sap1_controller.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/sap1_controller_if.sv
// Control-word bundle between the SAP-1 sequencer (master) and the datapath (slave).
// With SAP1_SINGLE_STEP_EN defined the bundle also carries the step_mode/step pushbutton inputs.
interface sap1_controller_if;
    logic [3:0] opcode;
    logic [2:0] tstate;
    logic       pc_inc;
    logic       pc_load;
    logic       pc_oe;
    logic       mar_load;
    logic       ram_oe;
    logic       ir_load;
    logic       ir_oe;
    logic       a_load;
    logic       a_oe;
    logic       b_load;
    logic       alu_sub;
    logic       alu_oe;
    logic       out_load;
    logic       halted;
`ifdef SAP1_SINGLE_STEP_EN
    logic       step_mode;
    logic       step;

    modport master (
        input  opcode, step_mode, step,
        output tstate, pc_inc, pc_load, pc_oe, mar_load, ram_oe, ir_load, ir_oe,
               a_load, a_oe, b_load, alu_sub, alu_oe, out_load, halted
    );

    modport slave (
        output opcode, step_mode, step,
        input  tstate, pc_inc, pc_load, pc_oe, mar_load, ram_oe, ir_load, ir_oe,
               a_load, a_oe, b_load, alu_sub, alu_oe, out_load, halted
    );
`else
    modport master (
        input  opcode,
        output tstate, pc_inc, pc_load, pc_oe, mar_load, ram_oe, ir_load, ir_oe,
               a_load, a_oe, b_load, alu_sub, alu_oe, out_load, halted
    );

    modport slave (
        output opcode,
        input  tstate, pc_inc, pc_load, pc_oe, mar_load, ram_oe, ir_load, ir_oe,
               a_load, a_oe, b_load, alu_sub, alu_oe, out_load, halted
    );
`endif
endinterface

// File: rtl/sap1_controller.sv
// SAP-1 control sequencer: six-state T-cycle plus opcode decode into the datapath control word.
// Optional single-step pushbutton mode is compiled in with SAP1_SINGLE_STEP_EN.
module sap1_controller #(
    parameter logic [3:0] OP_LDA     = 4'h0,
    parameter logic [3:0] OP_ADD     = 4'h1,
    parameter logic [3:0] OP_SUB     = 4'h2,
    parameter logic [3:0] OP_JMP     = 4'h6,
    parameter logic [3:0] OP_OUT     = 4'hE,
    parameter logic [3:0] OP_HLT     = 4'hF,
    parameter bit         FAST_CYCLE = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    sap1_controller_if.master   bus
);

    typedef enum logic [2:0] {
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4,
        T5 = 3'd5,
        T6 = 3'd6
    } tstate_t;

    tstate_t state;
    tstate_t state_next;
    logic    halted;
    logic    advance;

    logic is_lda, is_add, is_sub, is_jmp, is_out, is_hlt, is_alu;

    logic pc_inc, pc_load, pc_oe, mar_load, ram_oe, ir_load, ir_oe;
    logic a_load, a_oe, b_load, alu_sub, alu_oe, out_load;
    logic active;
    logic strobe_en;

`ifdef SAP1_SINGLE_STEP_EN
    logic step_meta, step_sync, step_prev, step_pulse;

    // Two-flop synchroniser on the raw pushbutton, then rising-edge detect to a one-cycle pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_meta <= 1'b0;
            step_sync <= 1'b0;
            step_prev <= 1'b0;
        end else begin
            step_meta <= bus.step;
            step_sync <= step_meta;
            step_prev <= step_sync;
        end
    end

    assign step_pulse = step_sync & ~step_prev;
    assign advance    = ~bus.step_mode | step_pulse;
`else
    assign advance = 1'b1;
`endif

    assign is_lda = (bus.opcode == OP_LDA);
    assign is_add = (bus.opcode == OP_ADD);
    assign is_sub = (bus.opcode == OP_SUB);
    assign is_jmp = (bus.opcode == OP_JMP);
    assign is_out = (bus.opcode == OP_OUT);
    assign is_hlt = (bus.opcode == OP_HLT);
    assign is_alu = is_add | is_sub;

    // Fast cycling cuts an instruction short once its last strobing state is done.
    always_comb begin
        state_next = T1;
        unique case (state)
            T1:      state_next = T2;
            T2:      state_next = T3;
            T3:      state_next = T4;
            T4:      state_next = (FAST_CYCLE && !(is_lda || is_alu || is_hlt)) ? T1 : T5;
            T5:      state_next = (FAST_CYCLE && is_lda) ? T1 : T6;
            T6:      state_next = T1;
            default: state_next = T1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= T1;
            halted <= 1'b0;
        end else if (!halted && advance) begin
            state <= state_next;
            if (state == T4 && is_hlt) begin
                halted <= 1'b1;
            end
        end
    end

    always_comb begin
        pc_inc   = 1'b0;
        pc_load  = 1'b0;
        pc_oe    = 1'b0;
        mar_load = 1'b0;
        ram_oe   = 1'b0;
        ir_load  = 1'b0;
        ir_oe    = 1'b0;
        a_load   = 1'b0;
        a_oe     = 1'b0;
        b_load   = 1'b0;
        alu_sub  = 1'b0;
        alu_oe   = 1'b0;
        out_load = 1'b0;
        unique case (state)
            T1: begin
                pc_oe    = 1'b1;
                mar_load = 1'b1;
            end
            T2: pc_inc = 1'b1;
            T3: begin
                ram_oe  = 1'b1;
                ir_load = 1'b1;
            end
            T4: begin
                if (is_lda || is_alu) begin
                    ir_oe    = 1'b1;
                    mar_load = 1'b1;
                end else if (is_jmp) begin
                    ir_oe   = 1'b1;
                    pc_load = 1'b1;
                end else if (is_out) begin
                    a_oe     = 1'b1;
                    out_load = 1'b1;
                end
            end
            T5: begin
                if (is_lda) begin
                    ram_oe = 1'b1;
                    a_load = 1'b1;
                end else if (is_alu) begin
                    ram_oe  = 1'b1;
                    b_load  = 1'b1;
                    alu_sub = is_sub;
                end
            end
            T6: begin
                if (is_alu) begin
                    alu_oe  = 1'b1;
                    a_load  = 1'b1;
                    alu_sub = is_sub;
                end
            end
            default: ;
        endcase
    end

    // Bus drivers follow the state whenever running; strobes also need an advancing cycle.
    assign active    = ~rst & ~halted;
    assign strobe_en = active & advance;

    assign bus.tstate   = state;
    assign bus.halted   = halted;
    assign bus.pc_oe    = active & pc_oe;
    assign bus.ram_oe   = active & ram_oe;
    assign bus.ir_oe    = active & ir_oe;
    assign bus.a_oe     = active & a_oe;
    assign bus.alu_oe   = active & alu_oe;
    assign bus.alu_sub  = active & alu_sub;
    assign bus.pc_inc   = strobe_en & pc_inc;
    assign bus.pc_load  = strobe_en & pc_load;
    assign bus.mar_load = strobe_en & mar_load;
    assign bus.ir_load  = strobe_en & ir_load;
    assign bus.a_load   = strobe_en & a_load;
    assign bus.b_load   = strobe_en & b_load;
    assign bus.out_load = strobe_en & out_load;

endmodule
